// File: rtl/zeroriscy_int_controller.sv
// Interrupt controller between the event unit and the core controller:
// captures a level request, presents it to the core, and pulses an ack back.
module zeroriscy_int_controller #(
  parameter int unsigned IRQ_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                irq_i,
  input  logic [IRQ_ID_W-1:0] irq_id_i,
  input  logic                m_irq_enable_i,
  input  logic                ctrl_ack_i,
  output logic                irq_req_ctrl_o,
  output logic [IRQ_ID_W-1:0] irq_id_ctrl_o,
  output logic [5:0]          csr_cause_o,
  output logic                irq_ack_o,
  output logic [IRQ_ID_W-1:0] irq_id_o
);

  localparam int unsigned CAUSE_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

  // State and captured ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Next state plus output decode; outputs depend on registered state only
  always_comb begin
    state_d        = state_q;
    irq_id_d       = irq_id_q;
    irq_req_ctrl_o = 1'b0;
    irq_id_ctrl_o  = '0;
    csr_cause_o    = '0;
    irq_ack_o      = 1'b0;
    irq_id_o       = '0;

    unique case (state_q)
      IDLE: begin
        if (irq_i && m_irq_enable_i) begin
          irq_id_d = irq_id_i;
          state_d  = PENDING;
        end
      end

      PENDING: begin
        irq_req_ctrl_o = 1'b1;
        irq_id_ctrl_o  = irq_id_q;
        csr_cause_o    = CAUSE_W'({1'b1, irq_id_q});
        // An ack taken by the core wins over a simultaneous enable drop
        if (ctrl_ack_i) begin
          state_d = ACK;
        end else if (!m_irq_enable_i) begin
          state_d = IDLE;
        end
      end

      ACK: begin
        irq_ack_o = 1'b1;
        irq_id_o  = irq_id_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_zeroriscy_int_controller.sv
// Self-checking bench for zeroriscy_int_controller: directed vector table,
// async reset sequences, and randomized traffic against a behavioural model.
module tb_zeroriscy_int_controller;

  logic       clk;
  logic       rst_n;
  logic       irq_i;
  logic [4:0] irq_id_i;
  logic       m_irq_enable_i;
  logic       ctrl_ack_i;
  logic       irq_req_ctrl_o;
  logic [4:0] irq_id_ctrl_o;
  logic [5:0] csr_cause_o;
  logic       irq_ack_o;
  logic [4:0] irq_id_o;

  int checks;
  int errors;

  zeroriscy_int_controller #(.IRQ_ID_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq_i),
    .irq_id_i       (irq_id_i),
    .m_irq_enable_i (m_irq_enable_i),
    .ctrl_ack_i     (ctrl_ack_i),
    .irq_req_ctrl_o (irq_req_ctrl_o),
    .irq_id_ctrl_o  (irq_id_ctrl_o),
    .csr_cause_o    (csr_cause_o),
    .irq_ack_o      (irq_ack_o),
    .irq_id_o       (irq_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       irq;
    logic [4:0] id;
    logic       en;
    logic       ack;
    logic       req;
    logic [4:0] idc;
    logic [5:0] cause;
    logic       acko;
    logic [4:0] ido;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  // Behavioural model: a request is either waiting for the core, being
  // acknowledged this cycle, or absent.
  bit       m_waiting;
  bit       m_acking;
  bit [4:0] m_id;

  function automatic vec_t mk(int irq, int id, int en, int ack,
                              int req, int idc, int cause, int acko, int ido);
    vec_t v;
    v.irq   = 1'(irq);
    v.id    = 5'(id);
    v.en    = 1'(en);
    v.ack   = 1'(ack);
    v.req   = 1'(req);
    v.idc   = 5'(idc);
    v.cause = 6'(cause);
    v.acko  = 1'(acko);
    v.ido   = 5'(ido);
    return v;
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 1'b0;
    m_acking  = 1'b0;
    m_id      = 5'd0;
  endtask

  task automatic model_edge(input bit irq, input bit [4:0] id, input bit en, input bit ack);
    if (m_acking) begin
      m_acking = 1'b0;
    end else if (m_waiting) begin
      if (ack) begin
        m_waiting = 1'b0;
        m_acking  = 1'b1;
      end else if (!en) begin
        m_waiting = 1'b0;
      end
    end else if (irq && en) begin
      m_waiting = 1'b1;
      m_id      = id;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"},   6'(irq_req_ctrl_o), 6'(m_waiting));
    chk({tag, "_idc"},   6'(irq_id_ctrl_o),  m_waiting ? 6'(m_id) : 6'd0);
    chk({tag, "_cause"}, csr_cause_o,        m_waiting ? {1'b1, m_id} : 6'd0);
    chk({tag, "_ack"},   6'(irq_ack_o),      6'(m_acking));
    chk({tag, "_ido"},   6'(irq_id_o),       m_acking ? 6'(m_id) : 6'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"},   6'(irq_req_ctrl_o), 6'd0);
    chk({tag, "_idc"},   6'(irq_id_ctrl_o),  6'd0);
    chk({tag, "_cause"}, csr_cause_o,        6'd0);
    chk({tag, "_ack"},   6'(irq_ack_o),      6'd0);
    chk({tag, "_ido"},   6'(irq_id_o),       6'd0);
  endtask

  // Drive at negedge, clock one rising edge, advance model, settle 1ns
  task automatic step(input logic irq, input logic [4:0] id, input logic en, input logic ack);
    @(negedge clk);
    irq_i          = irq;
    irq_id_i       = id;
    m_irq_enable_i = en;
    ctrl_ack_i     = ack;
    @(posedge clk);
    model_edge(irq, id, en, ack);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    irq_i          = 1'b0;
    irq_id_i       = 5'd0;
    m_irq_enable_i = 1'b0;
    ctrl_ack_i     = 1'b0;
    model_reset();

    //        irq id en ack | req idc cause acko ido
    tbl[0]  = mk(1, 11, 1, 0,  1, 11, 'h2B, 0, 0);
    tbl[1]  = mk(1, 11, 1, 0,  1, 11, 'h2B, 0, 0);
    tbl[2]  = mk(0,  0, 1, 1,  0,  0, 'h00, 1, 11);
    tbl[3]  = mk(0,  0, 1, 0,  0,  0, 'h00, 0, 0);
    tbl[4]  = mk(1,  3, 1, 0,  1,  3, 'h23, 0, 0);
    tbl[5]  = mk(1,  3, 0, 0,  0,  0, 'h00, 0, 0);
    tbl[6]  = mk(1,  3, 0, 0,  0,  0, 'h00, 0, 0);
    tbl[7]  = mk(1,  3, 1, 0,  1,  3, 'h23, 0, 0);
    tbl[8]  = mk(1,  3, 0, 1,  0,  0, 'h00, 1, 3);
    tbl[9]  = mk(0,  0, 1, 1,  0,  0, 'h00, 0, 0);
    tbl[10] = mk(0,  0, 1, 1,  0,  0, 'h00, 0, 0);
    tbl[11] = mk(1,  7, 1, 0,  1,  7, 'h27, 0, 0);
    tbl[12] = mk(1, 20, 1, 0,  1,  7, 'h27, 0, 0);
    tbl[13] = mk(0, 20, 1, 0,  1,  7, 'h27, 0, 0);
    tbl[14] = mk(1, 20, 1, 1,  0,  0, 'h00, 1, 7);
    tbl[15] = mk(1, 20, 1, 0,  0,  0, 'h00, 0, 0);
    tbl[16] = mk(1, 20, 1, 1,  1, 20, 'h34, 0, 0);
    tbl[17] = mk(0,  0, 1, 1,  0,  0, 'h00, 1, 20);
    tbl[18] = mk(0,  0, 0, 0,  0,  0, 'h00, 0, 0);

    // Reset is asynchronous: outputs are zero before any clock edge
    #2;
    check_zero("rst_async");
    // Request with enable during reset must not capture
    irq_i          = 1'b1;
    irq_id_i       = 5'd9;
    m_irq_enable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    irq_i          = 1'b0;
    m_irq_enable_i = 1'b0;
    rst_n          = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].irq, tbl[i].id, tbl[i].en, tbl[i].ack);
      chk($sformatf("vec%0d_req", i),   6'(irq_req_ctrl_o), 6'(tbl[i].req));
      chk($sformatf("vec%0d_idc", i),   6'(irq_id_ctrl_o),  6'(tbl[i].idc));
      chk($sformatf("vec%0d_cause", i), csr_cause_o,        tbl[i].cause);
      chk($sformatf("vec%0d_ack", i),   6'(irq_ack_o),      6'(tbl[i].acko));
      chk($sformatf("vec%0d_ido", i),   6'(irq_id_o),       6'(tbl[i].ido));
    end

    // Async reset mid-PENDING
    step(1'b1, 5'd9, 1'b1, 1'b0);
    chk("pend_req", 6'(irq_req_ctrl_o), 6'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_pend");
    model_reset();
    rst_n = 1'b1;
    irq_i = 1'b0;
    repeat (2) begin
      step(1'b0, 5'd9, 1'b1, 1'b1);
      check_zero("post_rst_pend");
    end

    // Async reset mid-ACK
    step(1'b1, 5'd17, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b1);
    chk("ack_pulse", 6'(irq_ack_o), 6'd1);
    chk("ack_id",    6'(irq_id_o),  6'd17);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_ack");
    model_reset();
    rst_n = 1'b1;
    repeat (2) begin
      step(1'b0, 5'd0, 1'b1, 1'b1);
      check_zero("post_rst_ack");
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 2) != 0), 5'($urandom),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0));
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
